// File: rtl/pwm_pkg.sv
// Shared constants for the PWM comparator slice: default width and the
// reset values of the duty double-buffer registers.
package pwm_pkg;

    localparam int PWM_WIDTH_DEF = 4;

    // Reset values for duty_active and pending. They are held at the maximum
    // legal width and sliced down to WIDTH where they are used.
    localparam logic [15:0] DUTY_ACTIVE_RST = 16'h0000;
    localparam logic [15:0] PENDING_RST     = 16'h0000;

endpackage

// File: rtl/pwm_comparator_wrap_detect.sv
// wrap_detect: remembers the previous counter sample and flags a wrap whenever
// the count decreases (unsigned). A counter that holds its value is not a wrap.
// Also registers the wrap as a one-cycle period tick. Usable by any consumer
// of the free-running counter.
module wrap_detect
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] binary,
    output logic             wrap,
    output logic             period_tick
);

    logic [WIDTH-1:0] prev;

    // A drop in value is a wrap. Because prev resets to 0, no wrap can be
    // seen in the first cycle after reset.
    assign wrap = (binary < prev);

    // Track the last sample and register the wrap pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev        <= '0;
            period_tick <= 1'b0;
        end else begin
            prev        <= binary;
            period_tick <= wrap;
        end
    end

endmodule

// File: rtl/pwm_comparator.sv
// pwm_comparator: compares the upstream counter value against a double-
// buffered duty value and produces a registered PWM output and period tick.
//
// Interface: duty_load is a single-cycle strobe with no back-pressure; the
// block always accepts it and the last strobe before a wrap wins.
//
// Build option PWM_INVERT_EN adds pwm_out_n, a registered complement of
// pwm_out (reset value 1). Without it the port and its register are absent.
module pwm_comparator
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] binary,
    input  logic [WIDTH-1:0] duty,
    input  logic             duty_load,
    output logic             pwm_out,
`ifdef PWM_INVERT_EN
    output logic             pwm_out_n,
`endif
    output logic             period_tick,
    output logic [WIDTH-1:0] duty_active
);

    logic             wrap;
    logic [WIDTH-1:0] pending;
    logic             pend_valid;
    logic [WIDTH-1:0] duty_eff;
    logic             cmp;

    wrap_detect #(
        .WIDTH (WIDTH)
    ) u_wrap_detect (
        .clk         (clk),
        .reset       (reset),
        .binary      (binary),
        .wrap        (wrap),
        .period_tick (period_tick)
    );

    // On a wrap with a pending value, the new duty already governs the first
    // sample of the new period, so the comparison looks through to pending.
    always_comb begin
        duty_eff = duty_active;
        if (wrap && pend_valid) begin
            duty_eff = pending;
        end
        cmp = (binary < duty_eff);
    end

    // Double buffer: loads land in pending; pending moves to active only at
    // a wrap. A load in the wrap cycle itself waits for the following wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending     <= PENDING_RST[WIDTH-1:0];
            pend_valid  <= 1'b0;
            duty_active <= DUTY_ACTIVE_RST[WIDTH-1:0];
        end else begin
            if (wrap && pend_valid) begin
                duty_active <= pending;
                pend_valid  <= 1'b0;
            end
            if (duty_load) begin
                pending    <= duty;
                pend_valid <= 1'b1;
            end
        end
    end

    // Registered PWM output, one cycle behind binary.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_out <= 1'b0;
        end else begin
            pwm_out <= cmp;
        end
    end

`ifdef PWM_INVERT_EN
    // Complementary output registered from the same comparison.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_out_n <= 1'b1;
        end else begin
            pwm_out_n <= ~cmp;
        end
    end
`endif

endmodule

// File: tb/tb_pwm_comparator.sv
// Testbench for pwm_comparator: directed counter sweeps with duty loads,
// a reference model pushing per-cycle expectations into exp_q, a monitor
// popping and comparing after each rising edge, and hand-computed per-period
// high-cycle and tick counts.
module tb_pwm_comparator;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] binary = '0;
  logic [W-1:0] duty = '0;
  logic         duty_load = 1'b0;
  logic         pwm_out;
  logic         period_tick;
  logic [W-1:0] duty_active;
`ifdef PWM_INVERT_EN
  logic         pwm_out_n;
`endif

  // clock / reset
  always #5 clk = ~clk;

  pwm_comparator #(
    .WIDTH (W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .binary      (binary),
    .duty        (duty),
    .duty_load   (duty_load),
    .pwm_out     (pwm_out),
`ifdef PWM_INVERT_EN
    .pwm_out_n   (pwm_out_n),
`endif
    .period_tick (period_tick),
    .duty_active (duty_active)
  );

  // expected entry: {pwm_out, period_tick, duty_active}
  logic [W+1:0] exp_q[$];

  int tests = 0;
  int fails = 0;
  int hi_cnt = 0;
  int tick_cnt = 0;

  // reference model state
  logic [W-1:0] m_prev = '0;
  logic [W-1:0] m_pend = '0;
  logic         m_pv = 1'b0;
  logic [W-1:0] m_act = '0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor
  initial begin
    logic [W+1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pwm_out", int'(pwm_out), int'(e[W+1]));
        check("period_tick", int'(period_tick), int'(e[W]));
        check("duty_active", int'(duty_active), int'(e[W-1:0]));
`ifdef PWM_INVERT_EN
        check("pwm_out_n", int'(pwm_out_n), int'(~e[W+1]));
`endif
        hi_cnt   += int'(pwm_out);
        tick_cnt += int'(period_tick);
      end
    end
  end

  // driver: one clock cycle of normal operation
  task automatic step(input logic [W-1:0] b, input logic ld, input logic [W-1:0] d);
    logic         wrap;
    logic [W-1:0] eff;
    logic         pwm;
    @(negedge clk);
    reset     = 1'b0;
    binary    = b;
    duty_load = ld;
    duty      = d;
    wrap = (b < m_prev);
    eff  = (wrap && m_pv) ? m_pend : m_act;
    pwm  = (b < eff);
    if (wrap && m_pv) begin
      m_act = m_pend;
      m_pv  = 1'b0;
    end
    if (ld) begin
      m_pend = d;
      m_pv   = 1'b1;
    end
    m_prev = b;
    exp_q.push_back({pwm, wrap, m_act});
  endtask

  // driver: one cycle with reset held, counter still moving
  task automatic reset_cycle();
    @(negedge clk);
    reset     = 1'b1;
    binary    = W'($urandom_range(0, 15));
    duty_load = 1'b0;
    m_prev = '0;
    m_pend = '0;
    m_pv   = 1'b0;
    m_act  = '0;
    exp_q.push_back('0);
    #1;
    check("rst_pwm_out", int'(pwm_out), 0);
    check("rst_duty_active", int'(duty_active), 0);
  endtask

  // driver: full 0..15 sweep, optional load at one count, then period totals
  task automatic run_period(input int load_at, input logic [W-1:0] d,
                            input int exp_hi, input int exp_ticks);
    hi_cnt   = 0;
    tick_cnt = 0;
    for (int b = 0; b < 16; b++) begin
      step(W'(b), (b == load_at), d);
    end
    @(posedge clk);
    #2;
    check("period_high", hi_cnt, exp_hi);
    check("period_ticks", tick_cnt, exp_ticks);
  endtask

  initial begin
    // 1: reset with binary toggling, then a first sweep with no wrap
    for (int i = 0; i < 4; i++) reset_cycle();
    run_period(-1, '0, 0, 0);

    // 2: load 5, applied at the next wrap, then 5 high cycles
    run_period(0, 4'd5, 0, 1);
    run_period(-1, '0, 5, 1);

    // 3: load 12 mid-period; current period keeps 5
    run_period(7, 4'd12, 5, 1);
    run_period(-1, '0, 12, 1);

    // 4: load 3 at 10, load 9 in the wrap cycle -> 3 then 9
    run_period(10, 4'd3, 12, 1);
    run_period(0, 4'd9, 3, 1);
    run_period(-1, '0, 9, 1);

    // 5: extremes and a hold at 15
    run_period(3, 4'd0, 9, 1);
    run_period(-1, '0, 0, 1);
    run_period(5, 4'd15, 0, 1);
    run_period(-1, '0, 15, 1);
    hi_cnt   = 0;
    tick_cnt = 0;
    for (int i = 0; i < 3; i++) step(4'd15, 1'b0, '0);
    @(posedge clk);
    #2;
    check("hold_high", hi_cnt, 0);
    check("hold_ticks", tick_cnt, 0);
    run_period(-1, '0, 15, 1);

    // 6: reset mid-period with a pending load
    for (int b = 0; b <= 6; b++) step(W'(b), (b == 3), 4'd7);
    @(posedge clk);
    #2;
    check("pre_rst_pwm_out", int'(pwm_out), 1);
    reset = 1'b1;
    #1;
    check("async_rst_pwm_out", int'(pwm_out), 0);
    check("async_rst_duty_active", int'(duty_active), 0);
`ifdef PWM_INVERT_EN
    check("async_rst_pwm_out_n", int'(pwm_out_n), 1);
`endif
    reset_cycle();
    reset_cycle();
    for (int b = 7; b < 16; b++) step(W'(b), 1'b0, '0);
    run_period(-1, '0, 0, 1);

    repeat (3) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // global time limit
  initial begin
    #200000;
    fails++;
    $display("FAIL timeout: simulation did not complete");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
